// File: rtl/riscv16_pkg.sv
// Shared widths and types for the 16-bit core's register file and write-back path.
package riscv16_pkg;

  localparam int unsigned REG_W     = 16;
  localparam int unsigned REGADDR_W = 3;
  localparam int unsigned NUM_REGS  = 8;

  typedef logic [REG_W-1:0]     word_t;
  typedef logic [REGADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MEM,
    GNT_ALU
  } wb_grant_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: claims on issue, releases on register-file commit,
// and stalls issue on RAW/WAW hazards against pending writes.
module wb_scoreboard
  import riscv16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  reg_addr_t           iss_src1,
  input  reg_addr_t           iss_src2,
  input  reg_addr_t           iss_tgt,
  input  logic                wb_we,
  input  reg_addr_t           wb_tgt,
  output logic                iss_stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                issue_fire;

  assign iss_stall  = iss_valid && (busy_q[iss_src1] || busy_q[iss_src2] || busy_q[iss_tgt]);
  assign issue_fire = iss_valid && !iss_stall;

  // A same-edge claim beats the release: the new owner holds the register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (issue_fire && (iss_tgt == reg_addr_t'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wb_we && (wb_tgt == reg_addr_t'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU and load results onto the single register-file write
// port through a register stage, with ALU starvation protection and an issue scoreboard.
module regfile_wb_sched
  import riscv16_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  reg_addr_t           alu_tgt,
  input  word_t               alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  reg_addr_t           mem_tgt,
  input  word_t               mem_data,
  output logic                mem_ready,
  input  logic                iss_valid,
  input  reg_addr_t           iss_src1,
  input  reg_addr_t           iss_src2,
  input  reg_addr_t           iss_tgt,
  output logic                iss_stall,
  output logic                we_reg,
  output reg_addr_t           tgt,
  output word_t               write_data,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [3:0] MaxStarve = 4'(MAX_STARVE);

  wb_grant_t grant;
  logic      accept;
  reg_addr_t sel_tgt;
  word_t     sel_data;

  logic [3:0] starve_q, starve_d;
  logic       we_q, we_d;
  reg_addr_t  tgt_q, tgt_d;
  word_t      data_q, data_d;

  // Loads win ties so the memory pipe drains, except when the ALU has waited too long.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        grant = (starve_q == MaxStarve) ? GNT_ALU : GNT_MEM;
      end else if (alu_valid) begin
        grant = GNT_ALU;
      end else if (mem_valid) begin
        grant = GNT_MEM;
      end
    end
  end

  assign alu_ready = (grant == GNT_ALU);
  assign mem_ready = (grant == GNT_MEM);
  assign accept    = (grant != GNT_NONE);
  assign sel_tgt   = (grant == GNT_ALU) ? alu_tgt : mem_tgt;
  assign sel_data  = (grant == GNT_ALU) ? alu_data : mem_data;

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || (grant == GNT_ALU)) begin
      starve_d = '0;
    end else if (starve_q < MaxStarve) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Writes to r0 are consumed but never reach the port; tgt/data hold otherwise.
  always_comb begin
    we_d   = accept && (sel_tgt != '0);
    tgt_d  = tgt_q;
    data_d = data_q;
    if (we_d) begin
      tgt_d  = sel_tgt;
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      tgt_q    <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      tgt_q    <= tgt_d;
      data_q   <= data_d;
    end
  end

  assign we_reg     = we_q;
  assign tgt        = tgt_q;
  assign write_data = data_q;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_src1  (iss_src1),
    .iss_src2  (iss_src2),
    .iss_tgt   (iss_tgt),
    .wb_we     (we_q),
    .wb_tgt    (tgt_q),
    .iss_stall (iss_stall),
    .busy      (busy)
  );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a behavioural register file on the write port.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, iss_valid;
  logic [2:0]  alu_tgt, mem_tgt, iss_src1, iss_src2, iss_tgt;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, iss_stall, we_reg;
  logic [2:0]  tgt;
  logic [15:0] write_data;
  logic [7:0]  busy;

  logic [15:0] rf [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(
    .MAX_STARVE (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_tgt    (alu_tgt),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_tgt    (mem_tgt),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .iss_valid  (iss_valid),
    .iss_src1   (iss_src1),
    .iss_src2   (iss_src2),
    .iss_tgt    (iss_tgt),
    .iss_stall  (iss_stall),
    .we_reg     (we_reg),
    .tgt        (tgt),
    .write_data (write_data),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (we_reg && tgt != 3'd0) rf[tgt] <= write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after a rising edge; inputs are then changed and settle for 1 more.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] alu_pat;
    alu_pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) rf[i] = '0;

    rst = 1'b1;
    alu_valid = 1'b1; alu_tgt = 3'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_tgt = 3'd2; mem_data = 16'h2222;
    iss_valid = 1'b0; iss_src1 = '0; iss_src2 = '0; iss_tgt = '0;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    tick(); tick();
    check("rst_we_reg", we_reg, 0);
    check("rst_busy", busy, 8'h00);
    check("rst_tgt", tgt, 0);
    check("rst_wdata", write_data, 0);

    rst = 1'b0; #1;
    check("post_rst_mem_ready", mem_ready, 1);
    check("post_rst_alu_ready", alu_ready, 0);
    tick();
    check("post_rst_we", we_reg, 1);
    check("post_rst_tgt", tgt, 3'd2);
    check("post_rst_wdata", write_data, 16'h2222);

    // Starvation: clear the counter, then hold both requesters valid.
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    alu_valid = 1'b1; mem_valid = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("starve_alu_%0d", i), alu_ready, alu_pat[i]);
      check($sformatf("starve_mem_%0d", i), mem_ready, !alu_pat[i]);
      tick();
    end
    check("starve_last_tgt", tgt, 3'd1);

    // Basic write-back to r3.
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    mem_valid = 1'b1; mem_tgt = 3'd3; mem_data = 16'hBEEF; #1;
    check("wb_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0; #1;
    check("wb_we", we_reg, 1);
    check("wb_tgt", tgt, 3'd3);
    check("wb_data", write_data, 16'hBEEF);
    tick();
    check("wb_rf_r3", rf[3], 16'hBEEF);
    check("wb_we_low", we_reg, 0);

    // Hazards on r5.
    iss_valid = 1'b1; iss_tgt = 3'd5; iss_src1 = 3'd0; iss_src2 = 3'd0; #1;
    check("haz_claim_stall", iss_stall, 0);
    tick();
    iss_valid = 1'b0; #1;
    check("haz_busy5", busy, 8'h20);
    iss_valid = 1'b1; iss_src1 = 3'd5; iss_tgt = 3'd6; #1;
    check("haz_raw_src1", iss_stall, 1);
    tick();
    check("haz_raw_hold", iss_stall, 1);
    check("haz_no_claim6", busy, 8'h20);
    iss_src1 = 3'd0; iss_src2 = 3'd5; #1;
    check("haz_raw_src2", iss_stall, 1);
    iss_src2 = 3'd0; iss_tgt = 3'd5; #1;
    check("haz_waw", iss_stall, 1);
    alu_valid = 1'b1; alu_tgt = 3'd5; alu_data = 16'h1234; #1;
    check("haz_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0; #1;
    check("haz_commit_we", we_reg, 1);
    check("haz_commit_tgt", tgt, 3'd5);
    check("haz_stall_n1", iss_stall, 1);
    tick();
    check("haz_stall_n2", iss_stall, 0);
    check("haz_busy_clr", busy, 8'h00);
    check("haz_rf_r5", rf[5], 16'h1234);
    iss_valid = 1'b0;

    // Same-edge commit and claim on r2: claim wins.
    mem_valid = 1'b1; mem_tgt = 3'd2; mem_data = 16'h5555; #1;
    check("sc_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    iss_valid = 1'b1; iss_tgt = 3'd2; iss_src1 = 3'd0; iss_src2 = 3'd0; #1;
    check("sc_we", we_reg, 1);
    check("sc_stall", iss_stall, 0);
    tick();
    iss_valid = 1'b0; #1;
    check("sc_busy2", busy, 8'h04);
    tick();
    check("sc_busy2_hold", busy, 8'h04);

    // Register 0: consumed and dropped, never claimed.
    mem_valid = 1'b1; mem_tgt = 3'd0; mem_data = 16'hAAAA; #1;
    check("r0_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0; #1;
    check("r0_we", we_reg, 0);
    check("r0_tgt_hold", tgt, 3'd2);
    check("r0_data_hold", write_data, 16'h5555);
    iss_valid = 1'b1; iss_tgt = 3'd0; #1;
    check("r0_iss_stall", iss_stall, 0);
    tick();
    iss_valid = 1'b0; #1;
    check("r0_busy", busy, 8'h04);

    // Reset mid-operation.
    mem_valid = 1'b1; mem_tgt = 3'd4; rst = 1'b1; #1;
    check("mid_rst_ready", mem_ready, 0);
    tick();
    check("mid_rst_busy", busy, 8'h00);
    check("mid_rst_we", we_reg, 0);
    rst = 1'b0; mem_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
